dev_bus_master: RTL and testbench
=================================

DEV_BUS_MASTER -- requirements
Module: dev_bus_master

Interface
REQ-001 The module SHALL have one parameter: TIMEOUT, default 16, the maximum number of WAIT cycles before a transfer is aborted (legal 2..255).
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, SHALL be asynchronous and active-low.
REQ-004 Port req_i, input, 1 bit: CPU transfer request, sampled on each rising edge.
REQ-005 Port rw_i, input, 1 bit: transfer direction, 1=read and 0=write, sampled with req_i.
REQ-006 Port sel_i, input, 2 bits: device register select, 00=kb data, 01=kb CSR, 10=scr data, 11=scr CSR.
REQ-007 Port wdata_i, input, 8 bits: write data, sampled with req_i.
REQ-008 Port rdata_o, output, 8 bits: read result, valid while done_o=1.
REQ-009 Port done_o, output, 1 bit: one-cycle completion pulse.
REQ-010 Port err_o, output, 1 bit: timeout flag, asserted together with done_o.
REQ-011 Port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-012 Port ovr_o, output, 1 bit: sticky request-overrun flag.
REQ-013 Port data_bus_o, output, 8 bits: data driven to the devices.
REQ-014 Port data_bus_i, input, 8 bits: data returned from the devices.
REQ-015 Port control_o, output, 2 bits: bus command, 00=idle, 01=read, 10=write; 11 SHALL never be driven.
REQ-016 Port sel_o, output, 2 bits: register select presented to the devices.
REQ-017 Port control_i, input, 2 bits: device acknowledge, 01=read ack, 10=write ack, others=none.

Function
REQ-018 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-019 In IDLE with req_i=1 or a pending request present, the module SHALL latch rw/sel/wdata into the command register and go to ISSUE on the next cycle; a pending request SHALL take priority over a new req_i.
REQ-020 In ISSUE, control_o SHALL be 01 (read) or 10 (write), sel_o SHALL be the latched select, data_bus_o SHALL be the latched wdata on writes and 00 on reads; the FSM SHALL go to WAIT unconditionally.
REQ-021 In WAIT, control_o, sel_o and data_bus_o SHALL hold their ISSUE values; a 16-bit-safe wait counter SHALL increment each cycle starting from 0.
REQ-022 In WAIT, a matching ack (01 for read, 10 for write) SHALL cause data_bus_i to be captured into rdata_o on reads, and the FSM SHALL go to DONE.
REQ-023 A non-matching ack SHALL be ignored.
REQ-024 In WAIT, when the counter reaches TIMEOUT-1 without an ack, the FSM SHALL go to DONE with the error flag set and rdata_o=FF.
REQ-025 An ack arriving in the same cycle as the timeout SHALL win, with no error.
REQ-026 In DONE: done_o=1 for exactly one cycle; err_o=error flag; control_o=00; next state IDLE.
REQ-027 Minimum latency from req_i sampled to done_o SHALL be 3 cycles (ack present in the first WAIT cycle).
REQ-028 Outside ISSUE and WAIT, control_o SHALL be 00 and data_bus_o SHALL be 00.
REQ-029 req_i=1 while busy_o=1 with no pending entry SHALL store the request in a 1-deep pending buffer.
REQ-030 req_i=1 while busy_o=1 with the buffer already full SHALL drop the request and set ovr_o; ovr_o SHALL clear only on reset.
REQ-031 req_i=1 in DONE SHALL be treated as busy and buffered.
REQ-032 rdata_o SHALL hold its last value until the next read completes.

Reset
REQ-033 While rst_n=0, regardless of clk, the module SHALL hold state=IDLE, control_o=00, sel_o=00, data_bus_o=00, rdata_o=00, done_o=0, err_o=0, busy_o=0 and ovr_o=0, and SHALL clear the pending buffer and wait counter.
REQ-034 Reset asserted mid-transfer SHALL abort the transfer with no done_o pulse.
REQ-035 After rst_n rises, the first req_i SHALL be accepted on the next rising edge.

Verification
REQ-036 Read scr CSR: req rw=1 sel=11, device returns control_i=01 with data_bus_i=10 on the first WAIT cycle -> control_o=01 for 2 cycles, done_o pulses 3 cycles after req, rdata_o=10, err_o=0.
REQ-037 Write scr data: rw=0 sel=10 wdata=61, ack 10 after 4 WAIT cycles -> data_bus_o=61 and control_o=10 held until the ack, done_o=1, err_o=0.
REQ-038 Timeout: read with no ack, TIMEOUT=16 -> done_o with err_o=1 and rdata_o=FF after 16 WAIT cycles; control_o=00 afterwards.
REQ-039 Back-to-back: three req_i on consecutive cycles -> the first two complete in order, the third is dropped, and ovr_o=1.
REQ-040 Ack on the timeout cycle -> err_o=0 and data is captured; wrong-type ack (10 during a read) is ignored.
REQ-041 rst_n low during WAIT -> all outputs 00/0 immediately, no done_o, and a new request after release completes normally.

Source files
------------

// File: rtl/dev_bus_master.sv
// Single-outstanding bus master: turns CPU requests into device read/write cycles,
// waits for a typed acknowledge with timeout, and buffers one request that arrives while busy.
module dev_bus_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic       rw_i,
  input  logic [1:0] sel_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       done_o,
  output logic       err_o,
  output logic       busy_o,
  output logic       ovr_o,
  output logic [7:0] data_bus_o,
  input  logic [7:0] data_bus_i,
  output logic [1:0] control_o,
  output logic [1:0] sel_o,
  input  logic [1:0] control_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [1:0] CtlIdle  = 2'b00;
  localparam logic [1:0] CtlRead  = 2'b01;
  localparam logic [1:0] CtlWrite = 2'b10;

  state_e      state_q, state_d;
  logic        cmd_rw_q, cmd_rw_d;
  logic [1:0]  cmd_sel_q, cmd_sel_d;
  logic [7:0]  cmd_wdata_q, cmd_wdata_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_rw_q, pend_rw_d;
  logic [1:0]  pend_sel_q, pend_sel_d;
  logic [7:0]  pend_wdata_q, pend_wdata_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        ovr_q, ovr_d;

  logic ack_match;
  logic timeout_hit;
  logic active;

  assign ack_match   = cmd_rw_q ? (control_i == CtlRead) : (control_i == CtlWrite);
  assign timeout_hit = (wait_cnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    cmd_rw_d     = cmd_rw_q;
    cmd_sel_d    = cmd_sel_q;
    cmd_wdata_d  = cmd_wdata_q;
    pend_valid_d = pend_valid_q;
    pend_rw_d    = pend_rw_q;
    pend_sel_d   = pend_sel_q;
    pend_wdata_d = pend_wdata_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    rdata_d      = rdata_q;
    ovr_d        = ovr_q;

    // Requests arriving while a transfer is in flight (including DONE) go to the buffer.
    if (state_q != StIdle && req_i) begin
      if (!pend_valid_q) begin
        pend_valid_d = 1'b1;
        pend_rw_d    = rw_i;
        pend_sel_d   = sel_i;
        pend_wdata_d = wdata_i;
      end else begin
        ovr_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (pend_valid_q) begin
          cmd_rw_d     = pend_rw_q;
          cmd_sel_d    = pend_sel_q;
          cmd_wdata_d  = pend_wdata_q;
          // The buffered request goes first; a simultaneous new one takes its slot.
          pend_valid_d = req_i;
          if (req_i) begin
            pend_rw_d    = rw_i;
            pend_sel_d   = sel_i;
            pend_wdata_d = wdata_i;
          end
          state_d = StIssue;
        end else if (req_i) begin
          cmd_rw_d    = rw_i;
          cmd_sel_d   = sel_i;
          cmd_wdata_d = wdata_i;
          state_d     = StIssue;
        end
      end
      StIssue: begin
        wait_cnt_d = '0;
        err_d      = 1'b0;
        state_d    = StWait;
      end
      StWait: begin
        // A matching ack wins over a timeout landing in the same cycle.
        if (ack_match) begin
          if (cmd_rw_q) rdata_d = data_bus_i;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = 8'hFF;
          state_d = StDone;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cmd_rw_q     <= 1'b0;
      cmd_sel_q    <= 2'b00;
      cmd_wdata_q  <= 8'h00;
      pend_valid_q <= 1'b0;
      pend_rw_q    <= 1'b0;
      pend_sel_q   <= 2'b00;
      pend_wdata_q <= 8'h00;
      wait_cnt_q   <= 16'h0000;
      err_q        <= 1'b0;
      rdata_q      <= 8'h00;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_rw_q     <= cmd_rw_d;
      cmd_sel_q    <= cmd_sel_d;
      cmd_wdata_q  <= cmd_wdata_d;
      pend_valid_q <= pend_valid_d;
      pend_rw_q    <= pend_rw_d;
      pend_sel_q   <= pend_sel_d;
      pend_wdata_q <= pend_wdata_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      ovr_q        <= ovr_d;
    end
  end

  assign active = (state_q == StIssue) || (state_q == StWait);

  always_comb begin
    control_o  = CtlIdle;
    sel_o      = 2'b00;
    data_bus_o = 8'h00;
    if (active) begin
      control_o  = cmd_rw_q ? CtlRead : CtlWrite;
      sel_o      = cmd_sel_q;
      data_bus_o = cmd_rw_q ? 8'h00 : cmd_wdata_q;
    end
  end

  assign done_o  = (state_q == StDone);
  assign err_o   = (state_q == StDone) && err_q;
  assign busy_o  = (state_q != StIdle);
  assign ovr_o   = ovr_q;
  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dev_bus_master.sv
// Directed bench for dev_bus_master: a vector table of single transfers plus
// hand-written back-to-back/overrun and mid-transfer reset sequences.
module tb_dev_bus_master;

  logic       clk;
  logic       rst_n;
  logic       req_i;
  logic       rw_i;
  logic [1:0] sel_i;
  logic [7:0] wdata_i;
  logic [7:0] rdata_o;
  logic       done_o;
  logic       err_o;
  logic       busy_o;
  logic       ovr_o;
  logic [7:0] data_bus_o;
  logic [7:0] data_bus_i;
  logic [1:0] control_o;
  logic [1:0] sel_o;
  logic [1:0] control_i;

  int n_cmp;
  int n_bad;

  dev_bus_master #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .rw_i       (rw_i),
    .sel_i      (sel_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .busy_o     (busy_o),
    .ovr_o      (ovr_o),
    .data_bus_o (data_bus_o),
    .data_bus_i (data_bus_i),
    .control_o  (control_o),
    .sel_o      (sel_o),
    .control_i  (control_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rw;
    logic [1:0] sel;
    logic [7:0] wdata;
    int         ack_at;     // WAIT-cycle index carrying the ack, -1 for none
    logic [1:0] ack;
    logic [1:0] noise;      // value on control_i in every other cycle
    logic [7:0] bus;
    int         exp_waits;
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic run_xfer(input vec_t v);
    logic [1:0] exp_ctl;
    logic [7:0] exp_dbus;
    bit         got;
    int         nw;
    exp_ctl  = v.rw ? 2'b01 : 2'b10;
    exp_dbus = v.rw ? 8'h00 : v.wdata;
    @(negedge clk);
    req_i = 1'b1; rw_i = v.rw; sel_i = v.sel; wdata_i = v.wdata; control_i = 2'b00;
    @(negedge clk);
    req_i = 1'b0;
    check("issue_ctl", 16'(control_o), 16'(exp_ctl));
    check("issue_sel", 16'(sel_o), 16'(v.sel));
    check("issue_dbus", 16'(data_bus_o), 16'(exp_dbus));
    check("issue_busy", 16'(busy_o), 16'd1);
    control_i = v.noise;
    @(negedge clk);
    got = 1'b0;
    nw  = 0;
    for (int k = 0; k < 64 && !got; k++) begin
      check("wait_ctl", 16'(control_o), 16'(exp_ctl));
      check("wait_dbus", 16'(data_bus_o), 16'(exp_dbus));
      control_i  = (k == v.ack_at) ? v.ack : v.noise;
      data_bus_i = v.bus;
      @(negedge clk);
      if (done_o) begin
        got = 1'b1;
        nw  = k + 1;
      end
    end
    control_i = 2'b00;
    check("done_seen", 16'(got), 16'd1);
    check("wait_cycles", 16'(nw), 16'(v.exp_waits));
    check("done_err", 16'(err_o), 16'(v.exp_err));
    check("done_rdata", 16'(rdata_o), 16'(v.exp_rdata));
    check("done_ctl", 16'(control_o), 16'd0);
    @(negedge clk);
    check("done_pulse_end", 16'(done_o), 16'd0);
    check("idle_busy", 16'(busy_o), 16'd0);
    check("idle_ctl", 16'(control_o), 16'd0);
  endtask

  initial begin
    int         ndone;
    logic [1:0] lc, ls;
    logic [7:0] ld;
    logic [1:0] rc [2];
    logic [1:0] rs [2];
    logic [7:0] rd [2];
    vec_t       post;

    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; req_i = 1'b0; rw_i = 1'b0; sel_i = 2'b00; wdata_i = 8'h00;
    data_bus_i = 8'h00; control_i = 2'b00;

    //         rw    sel    wdata  ack  ack    noise  bus    waits err   rdata
    vecs[0] = '{1'b1, 2'b11, 8'h00, 0,   2'b01, 2'b00, 8'h10, 1,    1'b0, 8'h10};
    vecs[1] = '{1'b0, 2'b10, 8'h61, 4,   2'b10, 2'b00, 8'h00, 5,    1'b0, 8'h10};
    vecs[2] = '{1'b1, 2'b00, 8'h00, -1,  2'b00, 2'b00, 8'h33, 16,   1'b1, 8'hFF};
    vecs[3] = '{1'b1, 2'b01, 8'h00, 15,  2'b01, 2'b10, 8'h5A, 16,   1'b0, 8'h5A};
    vecs[4] = '{1'b0, 2'b01, 8'hA5, 2,   2'b10, 2'b01, 8'hEE, 3,    1'b0, 8'h5A};
    vecs[5] = '{1'b1, 2'b10, 8'h00, 3,   2'b01, 2'b11, 8'h3C, 4,    1'b0, 8'h3C};

    #3;
    check("rst_ctl", 16'(control_o), 16'd0);
    check("rst_sel", 16'(sel_o), 16'd0);
    check("rst_dbus", 16'(data_bus_o), 16'd0);
    check("rst_rdata", 16'(rdata_o), 16'd0);
    check("rst_flags", 16'({done_o, err_o, busy_o, ovr_o}), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

    // Three requests on consecutive cycles with an immediately acking device.
    check("ovr_before", 16'(ovr_o), 16'd0);
    ndone = 0; lc = 2'b00; ls = 2'b00; ld = 8'h00;
    rc[0] = 2'b00; rc[1] = 2'b00; rs[0] = 2'b00; rs[1] = 2'b00; rd[0] = 8'h00; rd[1] = 8'h00;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_o) begin
        if (ndone < 2) begin
          rc[ndone] = lc; rs[ndone] = ls; rd[ndone] = ld;
        end
        ndone++;
      end
      if (control_o != 2'b00) begin
        lc = control_o; ls = sel_o; ld = data_bus_o;
      end
      control_i  = control_o;
      data_bus_i = 8'h99;
      case (i)
        0:       begin req_i = 1'b1; rw_i = 1'b1; sel_i = 2'b11; wdata_i = 8'h00; end
        1:       begin req_i = 1'b1; rw_i = 1'b0; sel_i = 2'b10; wdata_i = 8'h22; end
        2:       begin req_i = 1'b1; rw_i = 1'b1; sel_i = 2'b00; wdata_i = 8'h00; end
        default: req_i = 1'b0;
      endcase
    end
    control_i = 2'b00;
    check("b2b_ndone", 16'(ndone), 16'd2);
    check("b2b_first_ctl", 16'(rc[0]), 16'(2'b01));
    check("b2b_first_sel", 16'(rs[0]), 16'(2'b11));
    check("b2b_first_dbus", 16'(rd[0]), 16'h00);
    check("b2b_second_ctl", 16'(rc[1]), 16'(2'b10));
    check("b2b_second_sel", 16'(rs[1]), 16'(2'b10));
    check("b2b_second_dbus", 16'(rd[1]), 16'h22);
    check("b2b_ovr", 16'(ovr_o), 16'd1);
    check("b2b_rdata", 16'(rdata_o), 16'h99);
    check("b2b_busy", 16'(busy_o), 16'd0);

    // Reset asserted between clock edges while in WAIT.
    @(negedge clk);
    req_i = 1'b1; rw_i = 1'b1; sel_i = 2'b01;
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_before", 16'(busy_o), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", 16'(control_o), 16'd0);
    check("mid_rst_sel", 16'(sel_o), 16'd0);
    check("mid_rst_dbus", 16'(data_bus_o), 16'd0);
    check("mid_rst_rdata", 16'(rdata_o), 16'd0);
    check("mid_rst_flags", 16'({done_o, err_o, busy_o, ovr_o}), 16'd0);
    control_i = 2'b01; data_bus_i = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", 16'({done_o, busy_o}), 16'd0);
    end
    control_i = 2'b00;
    rst_n = 1'b1;
    post = '{1'b1, 2'b11, 8'h00, 1, 2'b01, 2'b00, 8'hC3, 2, 1'b0, 8'hC3};
    run_xfer(post);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
